// File: rtl/dsp_frame_sequencer_pkg.sv
// dsp_frame_sequencer_pkg: shared types and default sizing for the DSP frame sequencer.
//   DEF_NUM_CH / DEF_WIDTH / DEF_DRAIN : default channel count, sample width, pipeline drain
//   seq_state_t                        : sequencer FSM state encoding
//   sample_frame_t                     : one frame of samples at the default sizing
package dsp_frame_sequencer_pkg;
    localparam int DEF_NUM_CH = 8;
    localparam int DEF_WIDTH  = 36;
    localparam int DEF_DRAIN  = 3;

    typedef enum logic [1:0] {IDLE, START, RUN, CAPTURE} seq_state_t;

    typedef logic [DEF_NUM_CH-1:0][DEF_WIDTH-1:0] sample_frame_t;
endpackage

// File: rtl/dsp_frame_sequencer_out_buffer.sv
// frame_out_buffer: holding register for captured core results with valid/ready handshake.
//   clk, reset      : clock, asynchronous active-low reset
//   capture         : load capture_data this cycle
//   capture_data    : core results to hold
//   out_ready       : consumer takes out_data while out_valid is high
//   clear_stats     : clears the sticky drop flag (wins over a coincident drop)
//   out_data        : held frame
//   out_valid       : out_data holds an unconsumed frame
//   out_drop        : sticky, an unconsumed frame was overwritten
module frame_out_buffer
    import dsp_frame_sequencer_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WIDTH  = DEF_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           capture,
    input  logic [NUM_CH-1:0][WIDTH-1:0]   capture_data,
    input  logic                           out_ready,
    input  logic                           clear_stats,
    output logic [NUM_CH-1:0][WIDTH-1:0]   out_data,
    output logic                           out_valid,
    output logic                           out_drop
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_drop  <= 1'b0;
        end else begin
            // A capture always leaves valid high, even when the old frame is consumed in the same cycle.
            if (capture) begin
                out_data  <= capture_data;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (clear_stats)
                out_drop <= 1'b0;
            else if (capture && out_valid && !out_ready)
                out_drop <= 1'b1;
        end
    end
endmodule

// File: rtl/dsp_frame_sequencer.sv
// dsp_frame_sequencer: per-frame sequencing of a DSP core (latch samples, start, wait, capture).
//   clk, reset     : clock, asynchronous active-low reset
//   sample_tick    : frame strobe; accepted only in IDLE, otherwise counted as an overrun
//   in_data        : converter samples, latched into core_inputs on accept
//   prog_len       : core program length, latched on accept
//   core_start     : one-cycle start pulse to the core
//   core_inputs    : samples held for the core until the next accept
//   core_outputs   : core results, captured after prog_len + DRAIN run cycles
//   out_data/out_valid/out_ready : captured results and handshake
//   busy           : sequencer not in IDLE
//   clear_stats    : clears overrun_cnt and out_drop
//   overrun_cnt    : saturating count of rejected ticks
//   out_drop       : sticky, an unconsumed frame was overwritten
module dsp_frame_sequencer
    import dsp_frame_sequencer_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DRAIN  = DEF_DRAIN
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_tick,
    input  logic [NUM_CH-1:0][WIDTH-1:0]   in_data,
    input  logic [9:0]                     prog_len,
    output logic                           core_start,
    output logic [NUM_CH-1:0][WIDTH-1:0]   core_inputs,
    input  logic [NUM_CH-1:0][WIDTH-1:0]   core_outputs,
    output logic [NUM_CH-1:0][WIDTH-1:0]   out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    input  logic                           clear_stats,
    output logic [15:0]                    overrun_cnt,
    output logic                           out_drop
);
    seq_state_t  state, state_nxt;
    logic [9:0]  len_q;
    logic [15:0] cnt;
    logic [15:0] run_len;
    logic        accept;

    assign run_len = 16'(len_q) + 16'(DRAIN);

    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (sample_tick) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                core_start = 1'b1;
                state_nxt  = RUN;
            end
            // ">=" keeps a zero-length run from wrapping; it still leaves after one cycle.
            RUN:     state_nxt = (cnt + 16'd1 >= run_len) ? CAPTURE : RUN;
            CAPTURE: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            len_q       <= '0;
            core_inputs <= '0;
            overrun_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == RUN) ? cnt + 16'd1 : '0;
            if (accept) begin
                core_inputs <= in_data;
                len_q       <= prog_len;
            end
            if (clear_stats)
                overrun_cnt <= '0;
            else if (sample_tick && state != IDLE && overrun_cnt != 16'hFFFF)
                overrun_cnt <= overrun_cnt + 16'd1;
        end
    end

    frame_out_buffer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) u_out_buffer (
        .clk          (clk),
        .reset        (reset),
        .capture      (state == CAPTURE),
        .capture_data (core_outputs),
        .out_ready    (out_ready),
        .clear_stats  (clear_stats),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_drop     (out_drop)
    );
endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// tb_dsp_frame_sequencer: directed and randomized checks of dsp_frame_sequencer against a frame-level model.
module tb_dsp_frame_sequencer;
    import dsp_frame_sequencer_pkg::*;

    localparam int NUM_CH = DEF_NUM_CH;
    localparam int WIDTH  = DEF_WIDTH;
    localparam int DRAIN  = DEF_DRAIN;
    localparam int FW     = NUM_CH * WIDTH;

    typedef sample_frame_t frame_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic        out_ready = 1'b0;
    logic        clear_stats = 1'b0;
    logic [9:0]  prog_len = '0;
    frame_t      in_data = '0;
    frame_t      core_outputs = '0;
    logic        core_start, out_valid, busy, out_drop;
    frame_t      core_inputs, out_data;
    logic [15:0] overrun_cnt;

    dsp_frame_sequencer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DRAIN(DRAIN)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .in_data      (in_data),
        .prog_len     (prog_len),
        .core_start   (core_start),
        .core_inputs  (core_inputs),
        .core_outputs (core_outputs),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .clear_stats  (clear_stats),
        .overrun_cnt  (overrun_cnt),
        .out_drop     (out_drop)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level model: a frame accepted in cycle t occupies cycles t+1..t+2+len+DRAIN
    // and its capture happens at the end of the last of those cycles.
    int     cyc = 0;
    bit     in_flight = 1'b0;
    int     t_acc = -10;
    int     fin = -10;
    frame_t m_inputs = '0;
    frame_t m_out = '0;
    bit     m_valid = 1'b0;
    bit     m_drop = 1'b0;
    int     m_over = 0;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        logic [63:0] r;
        for (int i = 0; i < NUM_CH; i++) begin
            r = {$urandom, $urandom};
            f[i] = r[WIDTH-1:0];
        end
        return f;
    endfunction

    task automatic model_clear();
        in_flight = 1'b0;
        m_inputs  = '0;
        m_out     = '0;
        m_valid   = 1'b0;
        m_drop    = 1'b0;
        m_over    = 0;
        t_acc     = -10;
        fin       = -10;
    endtask

    // Advance one clock: update the model with the inputs seen at the edge, then check at the falling edge.
    task automatic step();
        bit busy_now;
        @(posedge clk);
        busy_now = in_flight;
        if (busy_now && cyc == fin) begin
            if (m_valid && !out_ready) m_drop = 1'b1;
            m_out     = core_outputs;
            m_valid   = 1'b1;
            in_flight = 1'b0;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (clear_stats) m_drop = 1'b0;
        if (clear_stats) m_over = 0;
        else if (sample_tick && busy_now && m_over < 65535) m_over++;
        if (sample_tick && !busy_now) begin
            t_acc     = cyc;
            fin       = cyc + 2 + int'(prog_len) + DRAIN;
            m_inputs  = in_data;
            in_flight = 1'b1;
        end
        cyc++;
        @(negedge clk);
        check("busy",        FW'(busy),        FW'(in_flight));
        check("core_start",  FW'(core_start),  FW'(in_flight && cyc == t_acc + 1));
        check("core_inputs", core_inputs,      m_inputs);
        check("out_valid",   FW'(out_valid),   FW'(m_valid));
        check("out_data",    out_data,         m_out);
        check("out_drop",    FW'(out_drop),    FW'(m_drop));
        check("overrun_cnt", FW'(overrun_cnt), FW'(m_over));
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b0;
        #1;
        model_clear();
        check("rst_busy",        FW'(busy),        '0);
        check("rst_core_start",  FW'(core_start),  '0);
        check("rst_out_valid",   FW'(out_valid),   '0);
        check("rst_out_drop",    FW'(out_drop),    '0);
        check("rst_overrun_cnt", FW'(overrun_cnt), '0);
        check("rst_core_inputs", core_inputs,      '0);
        check("rst_out_data",    out_data,         '0);
        repeat (hold) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_idle();
        sample_tick = 1'b0;
        for (int k = 0; k < 2000 && busy; k++) step();
        check("wait_idle", FW'(busy), '0);
    endtask

    initial begin
        int t0, nb, ns, base;
        frame_t pat, fa, fb;

        #2;
        do_reset(3);

        // Latency and latched inputs with prog_len = 25.
        for (int i = 0; i < NUM_CH; i++) pat[i] = WIDTH'((i + 1) << 10);
        in_data = pat;
        prog_len = 10'd25;
        core_outputs = rand_frame();
        sample_tick = 1'b1;
        t0 = cyc;
        step();
        check("t1_start_next", FW'(core_start), FW'(1));
        sample_tick = 1'b0;
        in_data = rand_frame();
        prog_len = 10'd3;
        for (int k = 0; k < 100 && !out_valid; k++) step();
        check("t1_valid_seen", FW'(out_valid), FW'(1));
        check("t1_latency", FW'(cyc - t0), FW'(3 + 25 + DRAIN));
        check("t1_core_inputs", core_inputs, pat);

        // Ticks at 0, 5, 10: one frame, two overruns.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        base = m_over;
        prog_len = 10'd25;
        nb = 0;
        ns = 0;
        for (int k = 0; k < 45; k++) begin
            sample_tick = (k == 0 || k == 5 || k == 10);
            in_data = rand_frame();
            step();
            nb += int'(busy);
            ns += int'(core_start);
        end
        sample_tick = 1'b0;
        check("t2_frames", FW'(ns), FW'(1));
        check("t2_overrun", FW'(overrun_cnt), FW'(base + 2));
        check("t2_busy_cycles", FW'(nb), FW'(2 + 25 + DRAIN));

        // Two frames with no consumer: second overwrites first and sets drop.
        out_ready = 1'b1;
        clear_stats = 1'b1;
        step();
        out_ready = 1'b0;
        clear_stats = 1'b0;
        fa = rand_frame();
        fb = rand_frame();
        prog_len = 10'd4;
        core_outputs = fa;
        sample_tick = 1'b1;
        step();
        wait_idle();
        check("t3_first_drop", FW'(out_drop), '0);
        core_outputs = fb;
        sample_tick = 1'b1;
        step();
        wait_idle();
        check("t3_drop", FW'(out_drop), FW'(1));
        check("t3_data", out_data, fb);

        // prog_len = 0: capture at +5, valid at +6.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        prog_len = 10'd0;
        sample_tick = 1'b1;
        t0 = cyc;
        step();
        sample_tick = 1'b0;
        nb = int'(busy);
        for (int k = 0; k < 20 && !out_valid; k++) begin
            step();
            nb += int'(busy);
        end
        check("t4_latency", FW'(cyc - t0), FW'(6));
        check("t4_busy_cycles", FW'(nb), FW'(2 + DRAIN));

        // Reset 10 cycles into a frame aborts it; a tick right after release is accepted.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        prog_len = 10'd25;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (9) step();
        #2;
        do_reset(2);
        for (int k = 0; k < 40; k++) step();
        check("t5_no_capture", FW'(out_valid), '0);
        sample_tick = 1'b1;
        prog_len = 10'd2;
        in_data = rand_frame();
        step();
        sample_tick = 1'b0;
        check("t5_accept_after_reset", FW'(busy), FW'(1));
        wait_idle();

        // Overrun saturation, then clear_stats beating a coincident rejected tick.
        out_ready = 1'b1;
        prog_len = 10'd1023;
        sample_tick = 1'b1;
        for (int k = 0; k < 70000 && m_over < 65535; k++) step();
        check("t6_saturated", FW'(overrun_cnt), FW'(16'hFFFF));
        for (int k = 0; k < 2000 && !in_flight; k++) step();
        step();
        check("t6_hold_max", FW'(overrun_cnt), FW'(16'hFFFF));
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        check("t6_clear_wins", FW'(overrun_cnt), '0);
        sample_tick = 1'b0;
        wait_idle();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            sample_tick  = ($urandom_range(0, 7) == 0);
            prog_len     = 10'($urandom_range(0, 20));
            out_ready    = ($urandom_range(0, 2) == 0);
            clear_stats  = ($urandom_range(0, 49) == 0);
            in_data      = rand_frame();
            core_outputs = rand_frame();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
